// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- serial UART transmitter.
//
// Sends one frame per accepted word on an idle-high line:
//   start bit (0), DATA_BITS data bits LSB first, optional parity bit,
//   stop bit (1) lasting STOP_BIT_TICKS ticks.
// Bit timing comes from tx_tick, an oversampling enable at 16 ticks per bit.
//
// Ports
//   sys_clk      : system clock, rising edge
//   rst          : synchronous active-high reset, aborts any frame
//   tx_tick      : 16x oversampling enable, one sys_clk wide
//   tx_start     : send request, honoured only while idle
//   tx_din       : word to send, captured on acceptance
//   tx_dout      : registered serial line
//   tx_busy      : high while a frame is in progress
//   tx_done_tick : one-cycle pulse in the last cycle of the stop bit
//   state_dbg    : current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
//
// Handshake: tx_start is a request sampled every cycle; it is accepted only
// when the FSM is IDLE (tx_busy=0). There is no queueing, so a request made
// while busy, or in the tx_done_tick cycle, is dropped.
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_BITS      = 8,
  parameter int STOP_BIT_TICKS = 16,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 tx_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_din,
  output logic                 tx_dout,
  output logic                 tx_busy,
  output logic                 tx_done_tick,
  output logic [2:0]           state_dbg
);

  // Tick counter must reach STOP_BIT_TICKS-1 when the stop bit is long.
  localparam int CW = (STOP_BIT_TICKS > 16) ? $clog2(STOP_BIT_TICKS) : 4;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST_TICK  = CW'(15);
  localparam logic [CW-1:0] STOP_LAST_TICK = CW'(STOP_BIT_TICKS - 1);
  localparam logic [BW-1:0] LAST_BIT       = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   dout_q, dout_d;
  logic                   done;
  logic                   bit_end;
  logic                   stop_end;

  // A counted tick that completes a 16-tick bit / the stop period.
  assign bit_end  = tx_tick && (tick_q == BIT_LAST_TICK);
  assign stop_end = tx_tick && (tick_q == STOP_LAST_TICK);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tx_tick ? (tick_q + CW'(1)) : tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        // Ticks are not counted while idle, including the acceptance cycle.
        tick_d = '0;
        if (tx_start) begin
          shreg_d = tx_din;
          par_d   = (^tx_din) ^ (PARITY_ODD != 0);
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          tick_d  = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tick_d  = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (stop_end) begin
          tick_d  = '0;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tick_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // The line value is computed from the next state so the registered
  // output lines up with the state register (no extra cycle of lag).
  always_comb begin
    dout_d = 1'b1;
    case (state_d)
      IDLE:    dout_d = 1'b1;
      START:   dout_d = 1'b0;
      DATA:    dout_d = shreg_d[0];
      PARITY:  dout_d = par_d;
      STOP:    dout_d = 1'b1;
      default: dout_d = 1'b1;
    endcase
  end

  assign tx_dout      = dout_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
// Three instances: default (8N1), even parity, odd parity. A line decoder
// reconstructs each frame from the selected instance and the scoreboard
// compares it with what was sent.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic            tx_tick = 1'b0;
  logic [2:0]      start_v = '0;
  logic [2:0][7:0] din_v   = '0;
  logic [2:0]      dout_v;
  logic [2:0]      busy_v;
  logic [2:0]      done_v;
  logic [2:0]      st0, st1, st2;

  uart_tx u_dut (
    .sys_clk(sys_clk), .rst(rst), .tx_tick(tx_tick),
    .tx_start(start_v[0]), .tx_din(din_v[0]),
    .tx_dout(dout_v[0]), .tx_busy(busy_v[0]), .tx_done_tick(done_v[0]),
    .state_dbg(st0)
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .sys_clk(sys_clk), .rst(rst), .tx_tick(tx_tick),
    .tx_start(start_v[1]), .tx_din(din_v[1]),
    .tx_dout(dout_v[1]), .tx_busy(busy_v[1]), .tx_done_tick(done_v[1]),
    .state_dbg(st1)
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .sys_clk(sys_clk), .rst(rst), .tx_tick(tx_tick),
    .tx_start(start_v[2]), .tx_din(din_v[2]),
    .tx_dout(dout_v[2]), .tx_busy(busy_v[2]), .tx_done_tick(done_v[2]),
    .state_dbg(st2)
  );

  // ---------------- bookkeeping ----------------
  int check_cnt = 0;
  int pass_cnt  = 0;
  int sel       = 0;   // instance under test
  int period    = 1;   // tx_tick every 'period' cycles
  int ph        = 0;
  int frames_sent = 0;
  int frames_seen = 0;

  logic [7:0] exp_q[$];
  logic       exp_par_q[$];
  int         exp_len_q[$];

  task automatic check(input string name, input int act, input int req);
    check_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_update();
    tx_tick = (ph == 0);
    ph = (ph + 1 >= period) ? 0 : ph + 1;
  endtask

  // Inputs for a cycle are applied 1 time unit after the rising edge;
  // returns 2 units after the edge so combinational outputs have settled.
  task automatic step();
    @(posedge sys_clk);
    #1;
    tick_update();
    #1;
  endtask

  function automatic int frame_len(input int s, input int p);
    return ((s == 0) ? 160 : 176) * p;
  endfunction

  // Present one request for one cycle; the tick phase restarts so the
  // first counted tick lands exactly 'period' cycles after acceptance.
  task automatic send(input logic [7:0] d, input logic par, input bit push);
    start_v[sel] = 1'b1;
    din_v[sel]   = d;
    ph = 0;
    tick_update();
    if (push) begin
      exp_q.push_back(d);
      exp_par_q.push_back(par);
      exp_len_q.push_back(frame_len(sel, period));
      frames_sent++;
    end
    step();
    start_v[sel] = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while (busy_v[sel] && k < max) begin
      step();
      k++;
    end
    check({"idle_in_time_", name}, int'(k < max), 1);
    step();
    step();
  endtask

  // ---------------- line decoder / scoreboard ----------------
  bit         mon_on = 0;
  int         mon_n, mon_blen, mon_dcnt, mon_dpos;
  logic [7:0] mon_data;
  logic       mon_par, mon_start, mon_stop;

  initial begin
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        mon_on = 0;
      end else begin
        if (!mon_on && busy_v[sel]) begin
          mon_on = 1; mon_n = 0; mon_blen = 0; mon_dcnt = 0; mon_dpos = -1;
          mon_data = '0; mon_par = 1'b0; mon_start = 1'b1; mon_stop = 1'b0;
        end
        if (mon_on) begin
          if (busy_v[sel]) begin
            mon_blen++;
            if (done_v[sel]) begin
              mon_dcnt++;
              mon_dpos = mon_blen;
            end
            // mon_n = counted ticks so far; sample in the middle of each bit.
            if (mon_n == 8) mon_start = dout_v[sel];
            if (mon_n >= 24 && mon_n < 152 && ((mon_n - 24) % 16) == 0)
              mon_data[(mon_n - 24) / 16] = dout_v[sel];
            if (sel != 0 && mon_n == 152) mon_par = dout_v[sel];
            if (mon_n == ((sel != 0) ? 168 : 152)) mon_stop = dout_v[sel];
            if (tx_tick) mon_n++;
          end else begin
            mon_on = 0;
            frames_seen++;
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 1, 0);
            end else begin
              logic [7:0] ed;
              logic       ep;
              int         el;
              ed = exp_q.pop_front();
              ep = exp_par_q.pop_front();
              el = exp_len_q.pop_front();
              check("frame_data", int'(mon_data), int'(ed));
              check("start_bit", int'(mon_start), 0);
              check("stop_bit", int'(mon_stop), 1);
              check("busy_len", mon_blen, el);
              check("done_count", mon_dcnt, 1);
              check("done_position", mon_dpos, el);
              if (sel != 0) check("parity_bit", int'(mon_par), int'(ep));
            end
          end
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int         s;
    logic [7:0] din;
    int         per;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    int errs, dcnt, dpos, cnt;
    logic [7:0] b;

    vecs[0] = '{s: 1, din: 8'h07, per: 1, par: 1'b1};
    vecs[1] = '{s: 2, din: 8'h07, per: 1, par: 1'b0};
    vecs[2] = '{s: 0, din: 8'h3C, per: 4, par: 1'b0};
    vecs[3] = '{s: 1, din: 8'h55, per: 1, par: 1'b0};
    vecs[4] = '{s: 2, din: 8'h55, per: 2, par: 1'b1};
    vecs[5] = '{s: 1, din: 8'h80, per: 1, par: 1'b1};
    vecs[6] = '{s: 0, din: 8'hFF, per: 3, par: 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_dout", int'(dout_v), 7);
    check("rst_busy", int'(busy_v), 0);
    check("rst_done", int'(done_v), 0);
    check("rst_state", int'(st0), 0);
    rst = 1'b0;
    repeat (3) step();

    // A5 with tick every cycle: exact cycle-by-cycle waveform
    sel = 0; period = 1;
    bits = {1'b1, 8'hA5, 1'b0};
    send(8'hA5, 1'b0, 1);
    errs = 0; dcnt = 0; dpos = -1;
    for (int i = 0; i < 160; i++) begin
      if (dout_v[0] !== bits[i / 16]) errs++;
      if (busy_v[0] !== 1'b1) errs++;
      if (done_v[0]) begin dcnt++; dpos = i; end
      step();
    end
    check("a5_waveform_errors", errs, 0);
    check("a5_done_count", dcnt, 1);
    check("a5_done_cycle", dpos, 159);
    check("a5_busy_after", int'(busy_v[0]), 0);
    check("a5_line_idle", int'(dout_v[0]), 1);
    step(); step();

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      sel = vecs[v].s; period = vecs[v].per;
      step();
      send(vecs[v].din, vecs[v].par, 1);
      wait_idle("table", 2000);
    end

    // Request while busy is ignored: 00 goes out, FF never does
    sel = 0; period = 1;
    send(8'h00, 1'b0, 1);
    repeat (50) step();
    start_v[0] = 1'b1; din_v[0] = 8'hFF;
    step();
    start_v[0] = 1'b0; din_v[0] = 8'h00;
    wait_idle("ignore", 400);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy_v[0]) cnt++;
      step();
    end
    check("no_second_frame", cnt, 0);

    // Reset aborts a frame during data bit 3
    send(8'hF0, 1'b0, 0);
    repeat (16 + 3 * 16 + 5 - 1) step();
    check("pre_abort_state", int'(st0), 2);
    rst = 1'b1;
    step();
    check("abort_dout", int'(dout_v[0]), 1);
    check("abort_busy", int'(busy_v[0]), 0);
    check("abort_done", int'(done_v[0]), 0);
    rst = 1'b0;
    step();
    send(8'h55, 1'b0, 1);
    wait_idle("after_abort", 400);

    // Request in the done cycle is dropped; the one in the next cycle wins
    send(8'h5A, 1'b0, 1);
    cnt = 0;
    while (!done_v[0] && cnt < 400) begin step(); cnt++; end
    check("done_seen", int'(cnt < 400), 1);
    start_v[0] = 1'b1; din_v[0] = 8'hE1;
    step();
    send(8'h1E, 1'b0, 1);
    wait_idle("done_cycle_start", 400);

    // Loopback: 256 random bytes back-to-back
    b = 8'($urandom_range(0, 255));
    send(b, 1'b0, 1);
    for (int i = 1; i < 256; i++) begin
      cnt = 0;
      while (!done_v[0] && cnt < 400) begin step(); cnt++; end
      if (cnt >= 400) begin
        check("loopback_done_timeout", 0, 1);
        break;
      end
      step();
      b = 8'($urandom_range(0, 255));
      send(b, 1'b0, 1);
    end
    wait_idle("loopback", 400);

    check("frames_seen", frames_seen, frames_sent);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
